// File: rtl/spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl
//   SPI master, mode 0, MSB first. Each accepted start pulse runs one
//   single-byte memory transaction against an SPI memory slave: a command
//   byte {addr[6:0], rw} followed either by the write data byte or by eight
//   bits captured from MISO into rdata. sclk is derived from clk.
//
//   Frame (D = CLK_DIV, G = GAP_CYCLES, C = CS_IDLE):
//     SETUP D | CMD 16D | GAP G | DATA 16D | HOLD D | RELEASE C | FINISH 1
//   cs_pin is low from SETUP through HOLD (34D+G cycles).
//
// Ports
//   clk        in   system clock, all logic on its rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   transaction request, only looked at while idle
//   rw         in   1 = read, 0 = write (captured with start)
//   addr[6:0]  in   memory address (captured with start)
//   wdata[7:0] in   write data (captured with start)
//   busy       out  high from the cycle after start is taken until done
//   done       out  one-cycle end-of-transaction pulse
//   rdata[7:0] out  read result, updated only when a read completes
//   sclk_pin   out  SPI clock, idles low
//   cs_pin     out  chip select, active low
//   mosi_pin   out  master-out data
//   miso_pin   in   master-in data, only used during a read data byte
// ----------------------------------------------------------------------------
module spi_master_ctrl #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 4,
   parameter int CS_IDLE    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sclk_pin,
   output logic       cs_pin,
   output logic       mosi_pin,
   input  logic       miso_pin
);

   // One counter is shared by every state; size it for the longest phase.
   localparam int PERIOD  = 2 * CLK_DIV;
   localparam int MAX_A   = (PERIOD > GAP_CYCLES) ? PERIOD : GAP_CYCLES;
   localparam int MAX_CNT = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
   localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PER_LAST  = CW'(PERIOD - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST  = CW'(CS_IDLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_CMD, S_GAP, S_DATA, S_HOLD, S_RELEASE, S_FINISH
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_cnt, bit_next;

   logic [7:0]    tx, tx_next;
   logic [7:0]    rx, rx_next;
   logic          rw_lat, rw_lat_next;
   logic [7:0]    wdata_lat, wdata_lat_next;
   logic [7:0]    rdata_next;
   logic          busy_next, done_next, sclk_next, cs_next;
   logic          sclk_fall;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_cnt <= bit_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. The cycle counter and bit counter restart on every
   // state entry so no phase inherits a partial count from the previous one.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      cnt_next   = cnt + CW'(1);
      bit_next   = bit_cnt;
      case (state)
         S_IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            if (start) state_next = S_SETUP;
         end
         S_SETUP: begin
            if (cnt == HALF_LAST) begin
               state_next = S_CMD;
               cnt_next   = '0;
               bit_next   = '0;
            end
         end
         S_CMD, S_DATA: begin
            if (cnt == PER_LAST) begin
               cnt_next = '0;
               if (bit_cnt == 3'd7) begin
                  state_next = (state == S_CMD) ? S_GAP : S_HOLD;
                  bit_next   = '0;
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_next = S_DATA;
               cnt_next   = '0;
               bit_next   = '0;
            end
         end
         S_HOLD: begin
            if (cnt == HALF_LAST) begin
               state_next = S_RELEASE;
               cnt_next   = '0;
            end
         end
         S_RELEASE: begin
            if (cnt == REL_LAST) begin
               state_next = S_FINISH;
               cnt_next   = '0;
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
            bit_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath logic. Pin values are derived from where the FSM
   // will be next cycle, so every pin comes straight from a flop.
   // ------------------------------------------------------------------
   always_comb begin
      tx_next        = tx;
      rx_next        = rx;
      rw_lat_next    = rw_lat;
      wdata_lat_next = wdata_lat;
      rdata_next     = rdata;

      // Edge that takes sclk from high to low inside a bit period.
      sclk_fall = ((state == S_CMD) || (state == S_DATA)) && (cnt == HALF_LAST);

      if ((state == S_IDLE) && start) begin
         tx_next        = {addr, rw};
         rw_lat_next    = rw;
         wdata_lat_next = wdata;
         rx_next        = '0;
      end else if (sclk_fall) begin
         // MOSI only moves on a falling sclk. The last fall of the command
         // byte already presents the first data bit (0 for reads), and the
         // last fall of the data byte parks MOSI low.
         if (bit_cnt != 3'd7)
            tx_next = {tx[6:0], 1'b0};
         else if ((state == S_CMD) && !rw_lat)
            tx_next = wdata_lat;
         else
            tx_next = '0;
      end

      // MISO is taken on the same clk edge that drives sclk high.
      if ((state_next == S_DATA) && (cnt_next == '0) && rw_lat)
         rx_next = {rx[6:0], miso_pin};

      if ((state_next == S_FINISH) && rw_lat)
         rdata_next = rx;

      sclk_next = ((state_next == S_CMD) || (state_next == S_DATA)) && (cnt_next < HALF);
      cs_next   = !(state_next inside {S_SETUP, S_CMD, S_GAP, S_DATA, S_HOLD});
      busy_next = !(state_next inside {S_IDLE, S_FINISH});
      done_next = (state_next == S_FINISH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx        <= '0;
         rx        <= '0;
         rw_lat    <= 1'b0;
         wdata_lat <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sclk_pin  <= 1'b0;
         cs_pin    <= 1'b1;
      end else begin
         tx        <= tx_next;
         rx        <= rx_next;
         rw_lat    <= rw_lat_next;
         wdata_lat <= wdata_lat_next;
         rdata     <= rdata_next;
         busy      <= busy_next;
         done      <= done_next;
         sclk_pin  <= sclk_next;
         cs_pin    <= cs_next;
      end
   end

   // The shift register's MSB is the MOSI flop.
   assign mosi_pin = tx[7];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Self-checking bench for spi_master_ctrl. Two instances: dut_a with the
//   default timing (D=4, G=4, C=2) and dut_b with D=1. Expected MOSI streams,
//   frame lengths and read data are derived from the transaction contents
//   and the frame-length formula, and compared with what is seen on the pins.
// ----------------------------------------------------------------------------
module tb_spi_master_ctrl;

   localparam int DIV_A = 4, GAP_A = 4, CSI_A = 2;
   localparam int DIV_B = 1, GAP_B = 4, CSI_B = 2;

   typedef struct {
      int          rises;
      logic [15:0] mosi_bits;
      int          first_low;
      int          last_low;
      int          low_count;
      int          done_cycle;
      int          done_count;
      int          busy_bad;
      int          sclk_bad;
      int          rdata_early;
      logic [7:0]  rdata_at_done;
      int          tail_active;
   } obs_t;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] start_v = '0;
   logic [1:0] rw_v    = '0;
   logic [1:0] miso_v  = '0;
   logic [6:0] addr_v  [2];
   logic [7:0] wdata_v [2];

   wire        a_busy, a_done, a_sclk, a_cs, a_mosi;
   wire        b_busy, b_done, b_sclk, b_cs, b_mosi;
   wire [7:0]  a_rdata, b_rdata;

   logic [1:0] busy_v, done_v, sclk_v, cs_v, mosi_v;
   logic [7:0] rdata_v [2];

   assign busy_v     = {b_busy, a_busy};
   assign done_v     = {b_done, a_done};
   assign sclk_v     = {b_sclk, a_sclk};
   assign cs_v       = {b_cs,   a_cs};
   assign mosi_v     = {b_mosi, a_mosi};
   assign rdata_v[0] = a_rdata;
   assign rdata_v[1] = b_rdata;

   int errors = 0;
   int checks = 0;
   logic [7:0] model_rdata [2];

   always #5 clk = ~clk;

   spi_master_ctrl #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A), .CS_IDLE(CSI_A)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_v[0]), .rw(rw_v[0]),
      .addr(addr_v[0]), .wdata(wdata_v[0]), .busy(a_busy), .done(a_done),
      .rdata(a_rdata), .sclk_pin(a_sclk), .cs_pin(a_cs), .mosi_pin(a_mosi),
      .miso_pin(miso_v[0])
   );

   spi_master_ctrl #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B), .CS_IDLE(CSI_B)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_v[1]), .rw(rw_v[1]),
      .addr(addr_v[1]), .wdata(wdata_v[1]), .busy(b_busy), .done(b_done),
      .rdata(b_rdata), .sclk_pin(b_sclk), .cs_pin(b_cs), .mosi_pin(b_mosi),
      .miso_pin(miso_v[1])
   );

   // ---------------- reference model ----------------
   function automatic int exp_n(input int sel);
      return (sel == 0) ? 34 * DIV_A + GAP_A : 34 * DIV_B + GAP_B;
   endfunction

   function automatic int exp_done(input int sel);
      return exp_n(sel) + ((sel == 0) ? CSI_A : CSI_B) + 1;
   endfunction

   function automatic logic [15:0] exp_mosi(input logic r, input logic [6:0] a, input logic [7:0] w);
      return {a, r, (r ? 8'h00 : w)};
   endfunction

   // Runs one transaction, acting as the SPI slave on MISO, and records what
   // the pins did. Must be entered just after a falling clk edge; returns just
   // after a falling edge. Cycle k is the cycle following start's sample edge.
   task automatic run_txn(input int sel, input logic t_rw, input logic [6:0] t_addr,
                          input logic [7:0] t_wdata, input logic [7:0] t_miso,
                          input bit keep_start, input int tail, output obs_t o);
      logic       prev_sclk;
      logic [7:0] r0;
      int         falls;
      int         t;
      bit         seen_done;
      o = '{default: 0};
      o.done_cycle = -1;
      o.first_low  = -1;
      rw_v[sel]    = t_rw;
      addr_v[sel]  = t_addr;
      wdata_v[sel] = t_wdata;
      start_v[sel] = 1'b1;
      miso_v[sel]  = 1'($urandom_range(0, 1));
      prev_sclk    = sclk_v[sel];
      r0           = rdata_v[sel];
      falls        = 0;
      t            = 0;
      seen_done    = 1'b0;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if ((k == 1) && !keep_start) begin
            // Scramble the request inputs to prove they were latched.
            start_v[sel] = 1'b0;
            rw_v[sel]    = 1'($urandom);
            addr_v[sel]  = 7'($urandom);
            wdata_v[sel] = 8'($urandom);
         end
         if (seen_done) begin
            t++;
            if (t == 1) start_v[sel] = 1'b0;
            if (done_v[sel]) o.done_count++;
            if (!cs_v[sel] || (sclk_v[sel] && !prev_sclk)) o.tail_active++;
            prev_sclk = sclk_v[sel];
            if (t >= tail) break;
            continue;
         end
         if (!cs_v[sel]) begin
            if (o.first_low < 0) o.first_low = k;
            o.last_low = k;
            o.low_count++;
         end
         if (sclk_v[sel] && cs_v[sel]) o.sclk_bad++;
         if (sclk_v[sel] && !prev_sclk) begin
            o.rises++;
            o.mosi_bits = {o.mosi_bits[14:0], mosi_v[sel]};
         end
         if (!sclk_v[sel] && prev_sclk) begin
            falls++;
            if ((falls >= 8) && (falls <= 15)) miso_v[sel] = t_miso[15 - falls];
         end
         prev_sclk = sclk_v[sel];
         if (done_v[sel]) begin
            o.done_cycle    = k;
            o.done_count++;
            o.rdata_at_done = rdata_v[sel];
            if (busy_v[sel]) o.busy_bad++;
            seen_done = 1'b1;
            if (tail == 0) break;
         end else begin
            if (!busy_v[sel]) o.busy_bad++;
            if (rdata_v[sel] !== r0) o.rdata_early++;
         end
      end
      start_v[sel] = 1'b0;
      $display("txn dut=%0d rw=%0b addr=%02h wdata=%02h miso=%02h mosi=%04h rises=%0d cs_low=%0d done_at=%0d rdata=%02h",
               sel, t_rw, t_addr, t_wdata, t_miso, o.mosi_bits, o.rises, o.low_count,
               o.done_cycle, o.rdata_at_done);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      model_rdata[0] = 8'h00;
      model_rdata[1] = 8'h00;
      for (int i = 0; i < 2; i++) begin
         addr_v[i]  = '0;
         wdata_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (cs_v[s] !== 1'b1) begin errors++; $display("FAIL reset_cs dut=%0d: got %b expected 1", s, cs_v[s]); end
         checks++;
         if (sclk_v[s] !== 1'b0) begin errors++; $display("FAIL reset_sclk dut=%0d: got %b expected 0", s, sclk_v[s]); end
         checks++;
         if (mosi_v[s] !== 1'b0) begin errors++; $display("FAIL reset_mosi dut=%0d: got %b expected 0", s, mosi_v[s]); end
         checks++;
         if ({busy_v[s], done_v[s]} !== 2'b00) begin errors++; $display("FAIL reset_busy_done dut=%0d: got %b%b expected 00", s, busy_v[s], done_v[s]); end
         checks++;
         if (rdata_v[s] !== model_rdata[s]) begin errors++; $display("FAIL reset_rdata dut=%0d: got %h expected %h", s, rdata_v[s], model_rdata[s]); end
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_basic();
      obs_t o;
      logic [15:0] em;
      em = exp_mosi(1'b0, 7'h15, 8'hA5);
      run_txn(0, 1'b0, 7'h15, 8'hA5, 8'($urandom), 1'b0, 0, o);
      checks++;
      if (o.mosi_bits !== em || o.rises != 16) begin errors++; $display("FAIL write_mosi: got %h rises=%0d expected %h rises=16", o.mosi_bits, o.rises, em); end
      checks++;
      if (o.done_cycle != exp_done(0)) begin errors++; $display("FAIL write_done_cycle: got %0d expected %0d", o.done_cycle, exp_done(0)); end
      checks++;
      if (o.first_low != 1 || o.last_low != exp_n(0) || o.low_count != exp_n(0)) begin
         errors++; $display("FAIL write_cs_window: got %0d..%0d (%0d) expected 1..%0d", o.first_low, o.last_low, o.low_count, exp_n(0));
      end
      checks++;
      if (o.busy_bad != 0) begin errors++; $display("FAIL write_busy: got %0d bad cycles expected 0", o.busy_bad); end
      checks++;
      if (o.rdata_at_done !== model_rdata[0] || o.rdata_early != 0) begin
         errors++; $display("FAIL write_rdata: got %h (early changes %0d) expected %h", o.rdata_at_done, o.rdata_early, model_rdata[0]);
      end
   endtask

   task automatic test_read_basic();
      obs_t o;
      logic [15:0] em;
      em = exp_mosi(1'b1, 7'h7F, 8'h00);
      @(negedge clk);
      run_txn(0, 1'b1, 7'h7F, 8'($urandom), 8'h3C, 1'b0, 0, o);
      model_rdata[0] = 8'h3C;
      checks++;
      if (o.mosi_bits !== em || o.rises != 16) begin errors++; $display("FAIL read_mosi: got %h rises=%0d expected %h rises=16", o.mosi_bits, o.rises, em); end
      checks++;
      if (o.rdata_at_done !== model_rdata[0]) begin errors++; $display("FAIL read_rdata: got %h expected %h", o.rdata_at_done, model_rdata[0]); end
      checks++;
      if (o.rdata_early != 0) begin errors++; $display("FAIL read_rdata_early: got %0d changes expected 0", o.rdata_early); end
      checks++;
      if (o.done_cycle != exp_done(0)) begin errors++; $display("FAIL read_done_cycle: got %0d expected %0d", o.done_cycle, exp_done(0)); end
   endtask

   task automatic test_start_spam();
      obs_t o;
      logic [6:0]  a;
      logic [7:0]  w;
      logic [15:0] em;
      a = 7'($urandom);
      w = 8'($urandom);
      em = exp_mosi(1'b0, a, w);
      @(negedge clk);
      run_txn(0, 1'b0, a, w, 8'($urandom), 1'b1, 20, o);
      checks++;
      if (o.rises != 16 || o.mosi_bits !== em) begin errors++; $display("FAIL spam_mosi: got %h rises=%0d expected %h rises=16", o.mosi_bits, o.rises, em); end
      checks++;
      if (o.done_count != 1) begin errors++; $display("FAIL spam_done_count: got %0d expected 1", o.done_count); end
      checks++;
      if (o.tail_active != 0 || o.sclk_bad != 0) begin
         errors++; $display("FAIL spam_extra_activity: got tail=%0d sclk_bad=%0d expected 0/0", o.tail_active, o.sclk_bad);
      end
   endtask

   task automatic test_reset_mid_data();
      obs_t        o;
      logic        prev;
      int          rises;
      int          bad;
      bit          hit;
      logic [6:0]  a;
      logic [7:0]  m;
      logic [15:0] em;
      rw_v[0]    = 1'b0;
      addr_v[0]  = 7'($urandom);
      wdata_v[0] = 8'($urandom);
      start_v[0] = 1'b1;
      prev  = 1'b0;
      rises = 0;
      hit   = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         start_v[0] = 1'b0;
         if (a_sclk && !prev) rises++;
         prev = a_sclk;
         if (rises == 12) begin hit = 1'b1; break; end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rst_reach_data: got %0d rises expected 12", rises); end
      reset_n = 1'b0;
      model_rdata[0] = 8'h00;
      model_rdata[1] = 8'h00;
      #1;
      checks++;
      if ({a_cs, a_sclk, a_busy, a_done} !== 4'b1000) begin
         errors++; $display("FAIL rst_immediate: got cs/sclk/busy/done=%b%b%b%b expected 1000", a_cs, a_sclk, a_busy, a_done);
      end
      checks++;
      if (a_rdata !== model_rdata[0]) begin errors++; $display("FAIL rst_rdata: got %h expected %h", a_rdata, model_rdata[0]); end
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (a_done || !a_cs || a_sclk) bad++;
      end
      reset_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (a_done || !a_cs || a_sclk) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles expected 0", bad); end
      a  = 7'($urandom);
      m  = 8'($urandom);
      em = exp_mosi(1'b1, a, 8'h00);
      run_txn(0, 1'b1, a, 8'($urandom), m, 1'b0, 0, o);
      model_rdata[0] = m;
      checks++;
      if (o.mosi_bits !== em || o.rdata_at_done !== model_rdata[0] || o.done_cycle != exp_done(0)) begin
         errors++; $display("FAIL rst_clean_txn: got mosi=%h rdata=%h done=%0d expected mosi=%h rdata=%h done=%0d",
                            o.mosi_bits, o.rdata_at_done, o.done_cycle, em, model_rdata[0], exp_done(0));
      end
   endtask

   task automatic test_div1();
      obs_t        o;
      logic [6:0]  a;
      logic [15:0] em;
      a  = 7'($urandom);
      em = exp_mosi(1'b1, a, 8'h00);
      @(negedge clk);
      run_txn(1, 1'b1, a, 8'($urandom), 8'h81, 1'b0, 0, o);
      model_rdata[1] = 8'h81;
      checks++;
      if (o.rdata_at_done !== model_rdata[1]) begin errors++; $display("FAIL div1_rdata: got %h expected %h", o.rdata_at_done, model_rdata[1]); end
      checks++;
      if (o.low_count != exp_n(1) || o.first_low != 1 || o.last_low != exp_n(1)) begin
         errors++; $display("FAIL div1_cs_low: got %0d cycles (%0d..%0d) expected %0d", o.low_count, o.first_low, o.last_low, exp_n(1));
      end
      checks++;
      if (o.mosi_bits !== em || o.rises != 16) begin errors++; $display("FAIL div1_mosi: got %h rises=%0d expected %h rises=16", o.mosi_bits, o.rises, em); end
      checks++;
      if (o.done_cycle != exp_done(1)) begin errors++; $display("FAIL div1_done_cycle: got %0d expected %0d", o.done_cycle, exp_done(1)); end
   endtask

   task automatic test_back_to_back();
      obs_t        o1, o2;
      logic [6:0]  a1, a2;
      logic [7:0]  w1, m2;
      int          gap;
      a1 = 7'($urandom);
      w1 = 8'($urandom);
      a2 = 7'($urandom);
      m2 = 8'($urandom);
      @(negedge clk);
      run_txn(0, 1'b0, a1, w1, 8'($urandom), 1'b0, 0, o1);
      gap = o1.done_cycle - o1.last_low;
      @(negedge clk);
      if (a_cs) gap++;
      run_txn(0, 1'b1, a2, 8'($urandom), m2, 1'b0, 0, o2);
      model_rdata[0] = m2;
      checks++;
      if (o1.mosi_bits !== exp_mosi(1'b0, a1, w1)) begin errors++; $display("FAIL b2b_write_mosi: got %h expected %h", o1.mosi_bits, exp_mosi(1'b0, a1, w1)); end
      checks++;
      if (o2.mosi_bits !== exp_mosi(1'b1, a2, 8'h00) || o2.rdata_at_done !== model_rdata[0]) begin
         errors++; $display("FAIL b2b_read: got mosi=%h rdata=%h expected mosi=%h rdata=%h", o2.mosi_bits, o2.rdata_at_done, exp_mosi(1'b1, a2, 8'h00), model_rdata[0]);
      end
      checks++;
      if (o2.first_low != 1) begin errors++; $display("FAIL b2b_accept: got cs low first at %0d expected 1", o2.first_low); end
      checks++;
      if (gap < CSI_A) begin errors++; $display("FAIL b2b_cs_gap: got %0d high cycles expected >= %0d", gap, CSI_A); end
   endtask

   task automatic test_random();
      obs_t        o;
      logic        r;
      logic [6:0]  a;
      logic [7:0]  w, m;
      logic [15:0] em;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 5; i++) begin
            r = 1'($urandom);
            a = 7'($urandom);
            w = 8'($urandom);
            m = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(s, r, a, w, m, 1'b0, 1, o);
            em = exp_mosi(r, a, w);
            if (r) model_rdata[s] = m;
            checks++;
            if (o.mosi_bits !== em || o.rises != 16) begin
               errors++; $display("FAIL rand_mosi dut=%0d: got %h rises=%0d expected %h rises=16", s, o.mosi_bits, o.rises, em);
            end
            checks++;
            if (o.rdata_at_done !== model_rdata[s] || o.rdata_early != 0) begin
               errors++; $display("FAIL rand_rdata dut=%0d: got %h (early %0d) expected %h", s, o.rdata_at_done, o.rdata_early, model_rdata[s]);
            end
            checks++;
            if (o.done_cycle != exp_done(s) || o.low_count != exp_n(s) || o.done_count != 1) begin
               errors++; $display("FAIL rand_timing dut=%0d: got done=%0d cs_low=%0d dones=%0d expected %0d/%0d/1",
                                  s, o.done_cycle, o.low_count, o.done_count, exp_done(s), exp_n(s));
            end
            checks++;
            if (o.busy_bad != 0 || o.sclk_bad != 0 || o.tail_active != 0) begin
               errors++; $display("FAIL rand_protocol dut=%0d: got busy_bad=%0d sclk_bad=%0d tail=%0d expected 0/0/0",
                                  s, o.busy_bad, o.sclk_bad, o.tail_active);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_start_spam();
      test_reset_mid_data();
      test_div1();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
